// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch aligner.
//   QDEPTH_HW : halfword queue depth
//   hw_t      : one 16-bit instruction parcel
//   is_compr  : 1 when a parcel starts a 16-bit (RVC) instruction
package fetch_pkg;

    localparam int unsigned QDEPTH_HW = 4;

    typedef logic [15:0] hw_t;

    function automatic logic is_compr(hw_t hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/PCAdder.sv
// Next-PC adder for the fetch stage.
//   pc      : PC of the current instruction
//   compr   : 1 when the instruction is 16-bit
//   pc_next : pc + 2 (compressed) or pc + 4
module PCAdder (
    input  logic [31:0] pc,
    input  logic        compr,
    output logic [31:0] pc_next
);

    assign pc_next = pc + (compr ? 32'd2 : 32'd4);

endmodule

// File: rtl/fetch_aligner.sv
// Instruction-fetch sequencer: owns the PC, issues word-aligned fetches and
// realigns returned halfwords into one 16- or 32-bit instruction per handshake.
//   clk, rst_n          : clock, asynchronous active-low reset
//   imem_req_*          : fetch request (valid/ready, word-aligned address)
//   imem_rsp_*          : fetch response pulse and data (no back-pressure)
//   redirect_valid/pc   : one-cycle control-flow redirect, flushes everything
//   out_valid/ready     : instruction handshake towards decode
//   out_inst/pc/compr   : instruction, its PC, and 16-bit flag
//   out_pc_next         : PC of the sequentially following instruction
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_compr,
    output logic [31:0] out_pc_next
);

    // Halfword queue, head at index 0; shifts down on dequeue.
    hw_t         q_q [QDEPTH_HW];
    hw_t         q_d [QDEPTH_HW];
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fetch_addr_q, fetch_addr_d;
    logic        outstanding_q, outstanding_d;
    logic        drop_q, drop_d;
    logic        skip_low_q, skip_low_d;
    logic        run_q;

    logic        head_compr;
    logic        out_fire;
    logic        req_fire;
    logic        rsp_take;
    logic        enq;
    logic [2:0]  n_out;
    logic [2:0]  n_in;
    logic [2:0]  base;
    hw_t         first_hw;

    assign head_compr = is_compr(q_q[0]);

    // Outputs depend only on registered state and redirect_valid.
    always_comb begin
        out_valid = !redirect_valid &&
                    ((cnt_q >= 3'd1 && head_compr) || cnt_q >= 3'd2);
        out_compr = out_valid && head_compr;
        out_inst  = '0;
        if (out_valid) begin
            out_inst = head_compr ? {16'h0000, q_q[0]} : {q_q[1], q_q[0]};
        end
        out_pc = pc_q;

        // Only request when a whole word is guaranteed to fit.
        imem_req_valid = run_q && !outstanding_q && (cnt_q <= 3'd2) && !redirect_valid;
        imem_req_addr  = fetch_addr_q;
    end

    PCAdder u_pc_adder (
        .pc      (out_pc),
        .compr   (out_compr),
        .pc_next (out_pc_next)
    );

    always_comb begin
        out_fire = out_valid && out_ready;
        req_fire = imem_req_valid && imem_req_ready;
        // A response with nothing outstanding (e.g. issued before a reset) is ignored.
        rsp_take = imem_rsp_valid && outstanding_q;
        enq      = rsp_take && !drop_q && !redirect_valid;

        n_out = 3'd0;
        if (out_fire) begin
            n_out = head_compr ? 3'd1 : 3'd2;
        end
        n_in = 3'd0;
        if (enq) begin
            n_in = skip_low_q ? 3'd1 : 3'd2;
        end
        base     = cnt_q - n_out;
        first_hw = skip_low_q ? imem_rsp_data[31:16] : imem_rsp_data[15:0];

        q_d = q_q;
        unique case (n_out)
            3'd1: begin
                q_d[0] = q_q[1];
                q_d[1] = q_q[2];
                q_d[2] = q_q[3];
            end
            3'd2: begin
                q_d[0] = q_q[2];
                q_d[1] = q_q[3];
            end
            default: ;
        endcase

        // Slot reservation keeps base <= 2 whenever data is enqueued.
        if (enq) begin
            q_d[base[1:0]] = first_hw;
            if (n_in == 3'd2) begin
                q_d[base[1:0] + 2'd1] = imem_rsp_data[31:16];
            end
        end

        cnt_d         = cnt_q - n_out + n_in;
        pc_d          = out_fire ? out_pc_next : pc_q;
        fetch_addr_d  = req_fire ? fetch_addr_q + 32'd4 : fetch_addr_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        skip_low_d    = skip_low_q;

        if (req_fire) begin
            outstanding_d = 1'b1;
        end
        if (rsp_take) begin
            outstanding_d = 1'b0;
            if (drop_q) begin
                drop_d = 1'b0;
            end else begin
                skip_low_d = 1'b0;
            end
        end

        // Redirect overrides everything else this cycle.
        if (redirect_valid) begin
            cnt_d        = 3'd0;
            pc_d         = redirect_pc & ~32'h1;
            fetch_addr_d = redirect_pc & ~32'h3;
            skip_low_d   = redirect_pc[1];
            // The in-flight word belongs to the old path; squash it when it lands.
            drop_d       = outstanding_q && !imem_rsp_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q           <= '{default: '0};
            cnt_q         <= 3'd0;
            pc_q          <= RESET_PC & ~32'h1;
            fetch_addr_q  <= RESET_PC & ~32'h3;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            skip_low_q    <= RESET_PC[1];
            run_q         <= 1'b0;
        end else begin
            q_q           <= q_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            fetch_addr_q  <= fetch_addr_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            skip_low_q    <= skip_low_d;
            run_q         <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
module tb_fetch_aligner;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_compr;
    logic [31:0] out_pc_next;

    fetch_aligner #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_compr      (out_compr),
        .out_pc_next    (out_pc_next)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        compr;
    } ent_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    ent_t        exp_q[$];
    ent_t        log_q[$];
    logic [31:0] model_pc;
    logic [31:0] mem [logic [31:0]];
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rnd_ready = 1'b0;
    int          req_fires = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout, want event", name);
    endtask

    // Memory image: filled lazily with random words, half the parcels 32-bit.
    function automatic logic [31:0] get_word(input logic [31:0] a);
        logic [31:0] w;
        if (!mem.exists(a)) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
            mem[a] = w;
        end
        return mem[a];
    endfunction

    function automatic logic [15:0] get_hw(input logic [31:0] a);
        logic [31:0] w;
        w = get_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Reference: the architectural instruction stream starting at model_pc.
    task automatic model_push(input int n);
        ent_t        e;
        logic [15:0] hw;
        for (int i = 0; i < n; i++) begin
            hw   = get_hw(model_pc);
            e.pc = model_pc;
            if (hw[1:0] != 2'b11) begin
                e.inst    = {16'h0000, hw};
                e.compr   = 1'b1;
                e.pc_next = model_pc + 32'd2;
            end else begin
                e.inst    = {get_hw(model_pc + 32'd2), hw};
                e.compr   = 1'b0;
                e.pc_next = model_pc + 32'd4;
            end
            exp_q.push_back(e);
            model_pc = e.pc_next;
        end
    endtask

    task automatic model_restart(input logic [31:0] pc);
        exp_q.delete();
        model_pc = {pc[31:1], 1'b0};
        model_push(16);
    endtask

    // Monitor: compares every delivered instruction against the scoreboard.
    initial begin
        ent_t e;
        ent_t a;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (imem_req_valid) begin
                    check("req_addr_align", {30'b0, imem_req_addr[1:0]}, 32'h0);
                    if (imem_req_ready) req_fires++;
                end
                if (!out_valid) begin
                    check("idle_out_zero", out_inst | {31'b0, out_compr}, 32'h0);
                end else if (out_ready) begin
                    a = '{inst: out_inst, pc: out_pc, pc_next: out_pc_next, compr: out_compr};
                    log_q.push_back(a);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out: got pc %h, want no output", out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_pc", a.pc, e.pc);
                        check("out_inst", a.inst, e.inst);
                        check("out_compr", {31'b0, a.compr}, {31'b0, e.compr});
                        check("out_pc_next", a.pc_next, e.pc_next);
                    end
                    if (exp_q.size() < 8) model_push(16);
                end
            end
        end
    end

    // Memory responder: one outstanding request, latency lat_min..lat_max cycles.
    initial begin
        bit          fire;
        bit          pend = 1'b0;
        logic [31:0] faddr;
        logic [31:0] paddr = '0;
        int          delay = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_req_ready = 1'b1;
        forever begin
            @(negedge clk);
            fire  = imem_req_valid && imem_req_ready;
            faddr = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (fire) begin
                pend  = 1'b1;
                paddr = faddr;
                delay = $urandom_range(lat_min, lat_max);
            end
            if (pend) begin
                delay--;
                if (delay == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = get_word(paddr);
                    pend           = 1'b0;
                end
            end
            imem_req_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_restart(RESET_PC);
        log_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input string name);
        int k = 0;
        while (log_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        if (log_q.size() < n) fail_now(name);
    endtask

    task automatic wait_req(input logic [31:0] addr, input string name);
        int  k = 0;
        bit  hit = 1'b0;
        while (!hit && k < 300) begin
            @(negedge clk);
            hit = imem_req_valid && imem_req_ready && imem_req_addr == addr;
            k++;
        end
        if (!hit) fail_now(name);
    endtask

    task automatic wait_any_req(output logic [31:0] addr, input string name);
        int  k = 0;
        bit  hit = 1'b0;
        addr = '0;
        while (!hit && k < 300) begin
            @(negedge clk);
            hit  = imem_req_valid && imem_req_ready;
            addr = imem_req_addr;
            k++;
        end
        if (!hit) fail_now(name);
    endtask

    initial begin
        logic [31:0] a;
        int          s;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset values and an all-32-bit stream, with first-output latency.
        mem.delete();
        mem[32'h0] = 32'h0000_0013;
        mem[32'h4] = 32'h0000_0013;
        model_restart(RESET_PC);
        log_q.delete();
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_compr", {31'b0, out_compr}, 32'h0);
        check("rst_out_pc", out_pc, RESET_PC);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("run_not_yet", {31'b0, imem_req_valid}, 32'h0);
        @(negedge clk);
        check("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_req_addr, 32'h0);
        @(negedge clk);
        check("no_out_at_rsp", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        check("first_out_valid", {31'b0, out_valid}, 32'h1);
        tick();
        wait_log(2, "stream32");
        if (log_q.size() >= 2) begin
            check("s32_pc0", log_q[0].pc, 32'h0);
            check("s32_pc1", log_q[1].pc, 32'h4);
            check("s32_next0", log_q[0].pc_next, 32'h4);
            check("s32_next1", log_q[1].pc_next, 32'h8);
            check("s32_compr", {31'b0, log_q[0].compr | log_q[1].compr}, 32'h0);
        end

        // Compressed pair in one word.
        mem.delete();
        mem[32'h0] = 32'h0001_4501;
        do_reset();
        wait_log(2, "compr_pair");
        if (log_q.size() >= 2) begin
            check("cp_inst0", log_q[0].inst, 32'h0000_4501);
            check("cp_inst1", log_q[1].inst, 32'h0000_0001);
            check("cp_pc1", log_q[1].pc, 32'h2);
            check("cp_compr", {31'b0, log_q[0].compr & log_q[1].compr}, 32'h1);
        end

        // 32-bit instruction straddling a word boundary.
        mem.delete();
        mem[32'h0] = 32'h0093_4501;
        mem[32'h4] = 32'h0000_0513;
        do_reset();
        wait_log(3, "straddle");
        if (log_q.size() >= 3) begin
            check("st_inst0", log_q[0].inst, 32'h0000_4501);
            check("st_inst1", log_q[1].inst, 32'h0513_0093);
            check("st_pc1", log_q[1].pc, 32'h2);
            check("st_next1", log_q[1].pc_next, 32'h6);
            check("st_inst2", log_q[2].inst, 32'h0000_0000);
            check("st_pc2", log_q[2].pc, 32'h6);
            check("st_compr2", {31'b0, log_q[2].compr}, 32'h1);
        end

        // Redirect to a halfword target while the fetch of 0x8 is in flight.
        mem.delete();
        mem[32'h100] = 32'h4501_0513;
        lat_min = 3;
        lat_max = 3;
        do_reset();
        wait_req(32'h8, "req_0x8");
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        model_restart(32'h102);
        log_q.delete();
        @(negedge clk);
        check("redir_out_gated", {31'b0, out_valid}, 32'h0);
        check("redir_req_gated", {31'b0, imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        wait_any_req(a, "req_after_redir");
        check("redir_req_addr", a, 32'h100);
        tick();
        wait_log(1, "redir_out");
        if (log_q.size() >= 1) begin
            check("redir_pc", log_q[0].pc, 32'h102);
            check("redir_inst", log_q[0].inst, 32'h0000_4501);
        end

        // Back-pressure: decode stalls for 10 cycles.
        lat_min = 1;
        lat_max = 1;
        log_q.delete();
        wait_log(3, "pre_stall");
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        s = req_fires;
        for (int i = 0; i < 5; i++) tick();
        check("stall_no_req", req_fires - s, 0);
        check("stall_holds_out", {31'b0, out_valid}, 32'h1);
        out_ready = 1'b1;
        log_q.delete();
        wait_log(6, "post_stall");

        // Asynchronous reset with a fetch in flight; the late response is ignored.
        mem.delete();
        mem[32'h0] = 32'h0001_0001;
        mem[32'h8] = 32'h0002_0002;
        lat_min = 3;
        lat_max = 3;
        do_reset();
        wait_req(32'h8, "req_0x8_b");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("arst_out_pc", out_pc, RESET_PC);
        check("arst_out_inst", out_inst | {31'b0, out_compr}, 32'h0);
        model_restart(RESET_PC);
        log_q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        wait_log(4, "after_arst");
        if (log_q.size() >= 1) begin
            check("arst_first_inst", log_q[0].inst, 32'h0000_0001);
            check("arst_first_pc", log_q[0].pc, 32'h0);
        end

        // Randomized traffic with random stalls, latencies and redirects.
        mem.delete();
        rnd_ready = 1'b1;
        lat_min   = 1;
        lat_max   = 3;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = (32'($urandom_range(0, 511)) << 1) | 32'($urandom_range(0, 1));
                model_restart(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        log_q.delete();
        wait_log(4, "final_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
